fifo_uart_tx: RTL and testbench

Drain-side consumer for the team's synchronous 8-bit FIFO. When the FIFO is non-empty and the block is enabled, it pops one word per frame and serializes it onto a UART line as 8N1 (start bit, 8 data bits LSB first, 1 stop bit). It sits between the FIFO read port (registered RAM read, one-cycle latency) and the chip's TX pad.

---
 rtl/fifo_uart_tx_if.sv | 33 +++
 rtl/fifo_uart_tx.sv | 106 ++++++++++
 tb/tb_fifo_uart_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Bundle of the FIFO read port, enable, and UART line/status signals for fifo_uart_tx.
// master is the transmitter side; slave is the FIFO/pad/controller side.
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops one word per frame from a registered-read FIFO and sends it as 8N1 UART, LSB first.
// Outputs are decoded from state or registered, so none depend combinationally on inputs.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.master bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StStart = 3'd3;
    localparam logic [2:0] StData  = 3'd4;
    localparam logic [2:0] StStop  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_done_q, tx_done_d;
    logic                  bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // fifo_empty is only looked at here, so a pop can never underflow.
                if (bus.enable && !bus.fifo_empty) state_d = StFetch;
            end
            StFetch: state_d = StWait;
            StWait: begin
                shift_d = bus.fifo_dout;
                cnt_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    tx_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Async reset of state_q forces the line high immediately.
    assign bus.tx         = (state_q == StStart) ? 1'b0 :
                            (state_q == StData)  ? shift_q[0] : 1'b1;
    assign bus.busy       = (state_q != StIdle);
    assign bus.fifo_rd_en = (state_q == StFetch);
    assign bus.tx_done    = tx_done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame-timeline reference model, line decoder, directed tests.
module tb_fifo_uart_tx;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int FRAME = 3 + 10 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // FIFO with registered read; single writer per variable.
    logic [7:0] mem [0:63];
    int wr_cnt    = 0;
    int rd_cnt    = 0;
    int underflow = 0;
    int cyc       = 0;
    assign bus.fifo_empty = (wr_cnt == rd_cnt);

    // Reference: offset of the current cycle within a frame (decision cycle = 0), -1 when idle.
    int         m_rel  = -1;
    logic [7:0] m_word = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rel <= -1;
        end else begin
            cyc <= cyc + 1;
            if (bus.fifo_rd_en) begin
                if (wr_cnt == rd_cnt) begin
                    underflow <= underflow + 1;
                end else begin
                    bus.fifo_dout <= mem[rd_cnt % 64];
                    rd_cnt        <= rd_cnt + 1;
                end
            end
            if (m_rel >= 1 && m_rel < FRAME) begin
                m_rel <= m_rel + 1;
            end else if (bus.enable && wr_cnt != rd_cnt) begin
                m_rel  <= 1;
                m_word <= mem[rd_cnt % 64];
            end else begin
                m_rel <= -1;
            end
        end
    end

    int n_total = 0;
    int n_bad   = 0;
    int n_print = 0;
    int busy_seen = 0;
    int rd_times[$];
    int done_times[$];

    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] a;
        logic [7:0] sh;
        logic       etx;
        etx = 1'b1;
        sh  = 8'h00;
        if (m_rel >= 3 && m_rel < 3 + N) begin
            etx = 1'b0;
        end else if (m_rel >= 3 + N && m_rel < 3 + 9 * N) begin
            sh  = m_word >> ((m_rel - 3 - N) / N);
            etx = sh[0];
        end
        e = {etx, (m_rel >= 1 && m_rel < FRAME), (m_rel == 1), (m_rel == FRAME)};
        a = {bus.tx, bus.busy, bus.fifo_rd_en, bus.tx_done};
        n_total++;
        if (a !== e) begin
            n_bad++;
            if (n_print < 20) begin
                $display("FAIL model cycle=%0d tx/busy/rd_en/done got=%b want=%b", cyc, a, e);
            end
            n_print++;
        end
        if (bus.fifo_rd_en) rd_times.push_back(cyc);
        if (bus.tx_done) done_times.push_back(cyc);
        if (bus.busy) busy_seen++;
    end

    // Independent line decoder sampling mid-bit.
    int         rx_t = -1;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_bytes[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_t = -1;
        end else if (rx_t < 0) begin
            if (bus.tx == 1'b0) rx_t = 0;
        end else begin
            rx_t++;
            if (rx_t >= N + N / 2 && rx_t < 9 * N && ((rx_t - N / 2) % N) == 0) begin
                rx_sh = {bus.tx, rx_sh[7:1]};
            end else if (rx_t == 9 * N + N / 2) begin
                if (bus.tx == 1'b1) rx_bytes.push_back(rx_sh);
                rx_t = -1;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt % 64] = b;
        wr_cnt++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_quiet(input int limit, input string name);
        int i;
        i = 0;
        while ((bus.busy || (bus.enable && wr_cnt != rd_cnt)) && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({"bounded_wait_", name}, int'(i < limit), 1);
    endtask

    function automatic int outs();
        return int'({bus.tx, bus.busy, bus.fifo_rd_en, bus.tx_done});
    endfunction

    initial begin
        int c;
        int rd_b;
        int dn_b;
        int rx_b;
        int bz_b;
        bus.enable = 1'b0;
        rst = 1'b1;
        tick(3);
        check("reset_outputs", outs(), 'b1000);
        rst = 1'b0;
        tick(2);
        check("idle_after_release", outs(), 'b1000);

        // Single byte 0xA5.
        rd_b = rd_times.size(); dn_b = done_times.size(); rx_b = rx_bytes.size();
        push(8'hA5);
        c = cyc;
        bus.enable = 1'b1;
        wait_quiet(200, "single");
        tick(2);
        check("single_pops", rd_times.size() - rd_b, 1);
        check("single_pop_cycle", rd_times[rd_b] - c, 1);
        check("single_done_cycle", done_times[dn_b] - c, 43);
        check("single_rx_count", rx_bytes.size() - rx_b, 1);
        check("single_rx_byte", int'(rx_bytes[rx_b]), 'hA5);

        // Empty FIFO with enable held high.
        rd_b = rd_times.size(); bz_b = busy_seen;
        tick(100);
        check("empty_no_pop", rd_times.size() - rd_b, 0);
        check("empty_never_busy", busy_seen - bz_b, 0);
        check("empty_tx_high", int'(bus.tx), 1);

        // Back-to-back 0x00, 0xFF, 0x3C.
        rd_b = rd_times.size(); dn_b = done_times.size(); rx_b = rx_bytes.size();
        push(8'h00); push(8'hFF); push(8'h3C);
        c = cyc;
        wait_quiet(400, "b2b");
        tick(2);
        check("b2b_pops", rd_times.size() - rd_b, 3);
        check("b2b_first_pop", rd_times[rd_b] - c, 1);
        check("b2b_gap1", rd_times[rd_b + 1] - rd_times[rd_b], 43);
        check("b2b_gap2", rd_times[rd_b + 2] - rd_times[rd_b + 1], 43);
        check("b2b_dones", done_times.size() - dn_b, 3);
        check("b2b_rx0", int'(rx_bytes[rx_b]), 'h00);
        check("b2b_rx1", int'(rx_bytes[rx_b + 1]), 'hFF);
        check("b2b_rx2", int'(rx_bytes[rx_b + 2]), 'h3C);
        check("b2b_fifo_empty", int'(bus.fifo_empty), 1);

        // Enable dropped during data bits of the first of two queued words.
        rd_b = rd_times.size(); dn_b = done_times.size(); rx_b = rx_bytes.size();
        push(8'h11); push(8'h5A);
        tick(3 + N + 4 * N);
        check("drop_in_frame", int'(bus.busy), 1);
        bus.enable = 1'b0;
        wait_quiet(200, "drop");
        tick(60);
        check("drop_pops", rd_times.size() - rd_b, 1);
        check("drop_dones", done_times.size() - dn_b, 1);
        check("drop_left_in_fifo", wr_cnt - rd_cnt, 1);
        check("drop_rx_count", rx_bytes.size() - rx_b, 1);
        check("drop_rx_byte", int'(rx_bytes[rx_b]), 'h11);

        // Reset during bit 3 of 0x5A; 0x77 must follow and 0x5A must not reappear.
        rd_b = rd_times.size(); dn_b = done_times.size(); rx_b = rx_bytes.size();
        push(8'h77);
        bus.enable = 1'b1;
        tick(20);
        check("rst_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("rst_outputs_immediate", outs(), 'b1000);
        tick(2);
        rst = 1'b0;
        wait_quiet(200, "after_rst");
        tick(2);
        check("rst_pops", rd_times.size() - rd_b, 2);
        check("rst_dones", done_times.size() - dn_b, 1);
        check("rst_rx_count", rx_bytes.size() - rx_b, 1);
        check("rst_rx_byte", int'(rx_bytes[rx_b]), 'h77);
        check("rst_fifo_empty", int'(bus.fifo_empty), 1);
        check("no_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
